oven_param_entry: RTL and testbench

- Parametrised digit-entry controller for the oven simulator front panel.
- The user dials each digit on switches and steps through it with active-low push buttons, entering first a temperature field and then a timer field.
- Adds over the previous entry logic: a synchronous reset, button synchronisation with press-edge detection, saturation of each digit to a maximum, a clear button, return from timer entry to temperature entry, and a done/valid flag.
- Sits between the board switches/buttons and the seven-segment decoders and oven controller.

---
 rtl/oven_entry_pkg.sv | 21 ++
 rtl/btn_edge_sync.sv | 25 ++
 rtl/oven_param_entry.sv | 132 +++++++++++++
 tb/tb_oven_param_entry.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_entry_pkg.sv
// rtl/oven_entry_pkg.sv - shared types, field codes and digit saturation for the oven entry panel
package oven_entry_pkg;

   typedef enum logic [1:0] {
      TEMP = 2'd0,
      TIME = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic FIELD_TEMP = 1'b0;
   localparam logic FIELD_TIME = 1'b1;

   // Wide enough for any practical digit width; callers cast in and out.
   localparam int SAT_W = 8;

   function automatic logic [SAT_W-1:0] sat_digit(input logic [SAT_W-1:0] i_val,
                                                  input logic [SAT_W-1:0] i_max);
      return (i_val > i_max) ? i_max : i_val;
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - three-flop synchroniser with a one-cycle press pulse on the falling pin edge
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_press
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
         r_s3 <= 1'b1;
      end else begin
         r_s1 <= i_btn_n;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_press = r_s3 & ~r_s2;

endmodule

// File: rtl/oven_param_entry.sv
// rtl/oven_param_entry.sv - temperature/timer digit entry controller for the oven front panel
module oven_param_entry
   import oven_entry_pkg::*;
#(
   parameter int DIGIT_W     = 4,
   parameter int DIGIT_MAX   = 9,
   parameter int TEMP_DIGITS = 3,
   parameter int TIME_DIGITS = 4,
   parameter int NUM_DISP    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIGIT_W-1:0]              sw,
   input  logic                            btn_next_n,
   input  logic                            btn_field_n,
   input  logic                            btn_clear_n,
   output logic [NUM_DISP*DIGIT_W-1:0]     disp,
   output logic [TEMP_DIGITS*DIGIT_W-1:0]  temp_val,
   output logic [TIME_DIGITS*DIGIT_W-1:0]  time_val,
   output logic [$clog2(NUM_DISP)-1:0]     cursor,
   output logic                            field,
   output logic                            done
);

   localparam int CUR_W = $clog2(NUM_DISP);

   logic w_next, w_field, w_clear;
   logic [DIGIT_W-1:0] w_digit;

   state_t r_state, w_state_nxt;
   logic [CUR_W-1:0] r_cursor, w_cursor_nxt;
   logic [TEMP_DIGITS-1:0][DIGIT_W-1:0] r_temp, w_temp_nxt;
   logic [TIME_DIGITS-1:0][DIGIT_W-1:0] r_time, w_time_nxt;
   logic [NUM_DISP-1:0][DIGIT_W-1:0] r_disp, w_disp_nxt;
   logic r_field, r_done, w_field_nxt, w_done_nxt;

   btn_edge_sync u_next  (.clk(clk), .rst(rst), .i_btn_n(btn_next_n),  .o_press(w_next));
   btn_edge_sync u_field (.clk(clk), .rst(rst), .i_btn_n(btn_field_n), .o_press(w_field));
   btn_edge_sync u_clear (.clk(clk), .rst(rst), .i_btn_n(btn_clear_n), .o_press(w_clear));

   assign w_digit = DIGIT_W'(sat_digit(SAT_W'(sw), SAT_W'(DIGIT_MAX)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= TEMP;
         r_cursor <= '0;
         r_temp   <= '0;
         r_time   <= '0;
         r_disp   <= '0;
         r_field  <= FIELD_TEMP;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cursor <= w_cursor_nxt;
         r_temp   <= w_temp_nxt;
         r_time   <= w_time_nxt;
         r_disp   <= w_disp_nxt;
         r_field  <= w_field_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // The active digit follows sw every cycle unless the field is being cleared.
   always_comb begin
      w_state_nxt  = r_state;
      w_cursor_nxt = r_cursor;
      w_temp_nxt   = r_temp;
      w_time_nxt   = r_time;
      case (r_state)
         TEMP: begin
            if (w_clear) begin
               w_temp_nxt   = '0;
               w_cursor_nxt = '0;
            end else begin
               for (int i = 0; i < TEMP_DIGITS; i++)
                  if (CUR_W'(i) == r_cursor) w_temp_nxt[i] = w_digit;
               if (w_field) begin
                  w_state_nxt  = TIME;
                  w_cursor_nxt = '0;
                  w_time_nxt   = '0;
               end else if (w_next && (r_cursor < CUR_W'(TEMP_DIGITS-1))) begin
                  w_cursor_nxt = r_cursor + CUR_W'(1);
               end
            end
         end
         TIME: begin
            if (w_clear) begin
               w_time_nxt   = '0;
               w_cursor_nxt = '0;
            end else begin
               for (int i = 0; i < TIME_DIGITS; i++)
                  if (CUR_W'(i) == r_cursor) w_time_nxt[i] = w_digit;
               if (w_field) begin
                  w_state_nxt  = TEMP;
                  w_cursor_nxt = '0;
               end else if (w_next) begin
                  if (r_cursor < CUR_W'(TIME_DIGITS-1)) w_cursor_nxt = r_cursor + CUR_W'(1);
                  else                                  w_state_nxt  = DONE;
               end
            end
         end
         DONE: begin
            if (w_clear) begin
               w_state_nxt  = TEMP;
               w_cursor_nxt = '0;
               w_temp_nxt   = '0;
               w_time_nxt   = '0;
            end
         end
         default: w_state_nxt = TEMP;
      endcase
   end

   always_comb begin
      w_field_nxt = (w_state_nxt == TEMP) ? FIELD_TEMP : FIELD_TIME;
      w_done_nxt  = (w_state_nxt == DONE);
      w_disp_nxt  = '0;
      if (w_state_nxt == TEMP) begin
         for (int i = 0; i < TEMP_DIGITS; i++) w_disp_nxt[i] = w_temp_nxt[i];
      end else begin
         for (int i = 0; i < TIME_DIGITS; i++) w_disp_nxt[i] = w_time_nxt[i];
      end
   end

   assign disp     = r_disp;
   assign temp_val = r_temp;
   assign time_val = r_time;
   assign cursor   = r_cursor;
   assign field    = r_field;
   assign done     = r_done;

endmodule

// File: tb/tb_oven_param_entry.sv
// tb/tb_oven_param_entry.sv - scoreboard bench for oven_param_entry against a behavioural entry model
module tb_oven_param_entry;

   localparam int DW   = 4;
   localparam int DMAX = 9;
   localparam int TD   = 3;
   localparam int MD   = 4;
   localparam int ND   = 4;
   localparam int CW   = $clog2(ND);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [DW-1:0] sw = '0;
   logic btn_next_n = 1'b1, btn_field_n = 1'b1, btn_clear_n = 1'b1;
   logic [ND*DW-1:0] disp;
   logic [TD*DW-1:0] temp_val;
   logic [MD*DW-1:0] time_val;
   logic [CW-1:0] cursor;
   logic field, done;

   oven_param_entry #(.DIGIT_W(DW), .DIGIT_MAX(DMAX), .TEMP_DIGITS(TD),
                      .TIME_DIGITS(MD), .NUM_DISP(ND)) dut (
      .clk(clk), .rst(rst), .sw(sw),
      .btn_next_n(btn_next_n), .btn_field_n(btn_field_n), .btn_clear_n(btn_clear_n),
      .disp(disp), .temp_val(temp_val), .time_val(time_val),
      .cursor(cursor), .field(field), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   typedef struct {
      logic [ND*DW-1:0] disp;
      logic [TD*DW-1:0] temp;
      logic [MD*DW-1:0] tim;
      logic [CW-1:0]    cur;
      logic             fld;
      logic             dn;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: plain integers, a mode number and arrays of digits.
   int m_mode;
   int m_cur;
   int m_temp[TD];
   int m_time[MD];
   int h_next[$], h_field[$], h_clear[$];

   // A press acts when the pin was high three edges ago and low two edges ago.
   function automatic bit pressed(input int q[$]);
      if (q.size() < 3) return 1'b0;
      return (q[q.size()-2] == 0) && (q[q.size()-3] == 1);
   endfunction

   function automatic void push_hist(inout int q[$], input int v);
      q.push_back(v);
      while (q.size() > 3) void'(q.pop_front());
   endfunction

   always @(posedge clk) begin
      bit p_n, p_f, p_c;
      int d;
      exp_t e;
      if (rst) begin
         m_mode = 0;
         m_cur  = 0;
         foreach (m_temp[i]) m_temp[i] = 0;
         foreach (m_time[i]) m_time[i] = 0;
         h_next  = '{1, 1, 1};
         h_field = '{1, 1, 1};
         h_clear = '{1, 1, 1};
      end else begin
         p_n = pressed(h_next);
         p_f = pressed(h_field);
         p_c = pressed(h_clear);
         d = (int'(sw) > DMAX) ? DMAX : int'(sw);
         if (m_mode == 0) begin
            if (p_c) begin
               foreach (m_temp[i]) m_temp[i] = 0;
               m_cur = 0;
            end else begin
               m_temp[m_cur] = d;
               if (p_f) begin
                  m_mode = 1;
                  m_cur = 0;
                  foreach (m_time[i]) m_time[i] = 0;
               end else if (p_n && m_cur < TD-1) m_cur++;
            end
         end else if (m_mode == 1) begin
            if (p_c) begin
               foreach (m_time[i]) m_time[i] = 0;
               m_cur = 0;
            end else begin
               m_time[m_cur] = d;
               if (p_f) begin
                  m_mode = 0;
                  m_cur = 0;
               end else if (p_n) begin
                  if (m_cur < MD-1) m_cur++;
                  else m_mode = 2;
               end
            end
         end else if (p_c) begin
            m_mode = 0;
            m_cur = 0;
            foreach (m_temp[i]) m_temp[i] = 0;
            foreach (m_time[i]) m_time[i] = 0;
         end
         push_hist(h_next,  int'(btn_next_n));
         push_hist(h_field, int'(btn_field_n));
         push_hist(h_clear, int'(btn_clear_n));
      end
      e.temp = '0;
      e.tim  = '0;
      e.disp = '0;
      for (int i = 0; i < TD; i++) e.temp[i*DW +: DW] = DW'(m_temp[i]);
      for (int i = 0; i < MD; i++) e.tim[i*DW +: DW]  = DW'(m_time[i]);
      if (m_mode == 0) for (int i = 0; i < TD; i++) e.disp[i*DW +: DW] = DW'(m_temp[i]);
      else             for (int i = 0; i < MD; i++) e.disp[i*DW +: DW] = DW'(m_time[i]);
      e.cur = CW'(m_cur);
      e.fld = (m_mode != 0);
      e.dn  = (m_mode == 2);
      sb_q.push_back(e);
   end

   bit   mon_seen = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (sb_q.size() == 0) begin
         if (mon_seen) chk("sb_underflow", 32'd0, 32'd1);
      end else begin
         mon_seen = 1'b1;
         mon_e = sb_q.pop_front();
         chk("sb_disp",     32'(disp),     32'(mon_e.disp));
         chk("sb_temp_val", 32'(temp_val), 32'(mon_e.temp));
         chk("sb_time_val", 32'(time_val), 32'(mon_e.tim));
         chk("sb_cursor",   32'(cursor),   32'(mon_e.cur));
         chk("sb_field",    32'(field),    32'(mon_e.fld));
         chk("sb_done",     32'(done),     32'(mon_e.dn));
      end
   end

   // One-sample press; returns on the falling edge just after the press has acted.
   task automatic tap(input bit n, input bit f, input bit c);
      @(negedge clk);
      btn_next_n = ~n; btn_field_n = ~f; btn_clear_n = ~c;
      @(negedge clk);
      btn_next_n = 1'b1; btn_field_n = 1'b1; btn_clear_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      n_err++;
      summary();
      $finish;
   end

   logic [TD*DW-1:0] temp_snap;
   logic [CW-1:0]    cur_snap;

   initial begin
      sw = DW'($urandom_range(0, 15));
      repeat (2) @(negedge clk);
      chk("rst_temp",   32'(temp_val), 32'd0);
      chk("rst_time",   32'(time_val), 32'd0);
      chk("rst_cursor", 32'(cursor),   32'd0);
      chk("rst_field",  32'(field),    32'd0);
      chk("rst_done",   32'(done),     32'd0);
      chk("rst_disp",   32'(disp),     32'd0);
      rst = 1'b0;

      sw = 4'd3;  tap(1, 0, 0);
      sw = 4'd5;  tap(1, 0, 0);
      sw = 4'd12; repeat (2) @(negedge clk);
      chk("temp_entry_sat", 32'(temp_val), 32'h953);
      chk("temp_disp",      32'(disp),     32'h0953);
      chk("temp_cursor",    32'(cursor),   32'd2);
      tap(1, 0, 0);
      chk("temp_cursor_hold", 32'(cursor), 32'd2);

      tap(0, 1, 0);
      chk("fsw_field", 32'(field),    32'd1);
      chk("fsw_time",  32'(time_val), 32'd0);
      chk("fsw_disp",  32'(disp),     32'd0);
      chk("fsw_temp",  32'(temp_val), 32'h953);

      sw = 4'd1; tap(1, 0, 0);
      sw = 4'd2; tap(1, 0, 0);
      sw = 4'd0; tap(1, 0, 0);
      chk("time_not_done", 32'(done), 32'd0);
      sw = 4'd5; tap(1, 0, 0);
      chk("time_done",     32'(done),     32'd1);
      chk("time_val_full", 32'(time_val), 32'h5021);
      chk("done_disp",     32'(disp),     32'h5021);

      repeat (8) begin
         @(negedge clk);
         sw = DW'($urandom_range(0, 15));
      end
      @(negedge clk);
      chk("frozen_time", 32'(time_val), 32'h5021);
      chk("frozen_temp", 32'(temp_val), 32'h953);
      tap(1, 1, 0);
      chk("frozen_ignore_btn", 32'(done), 32'd1);

      tap(0, 0, 1);
      chk("restart_done",  32'(done),     32'd0);
      chk("restart_field", 32'(field),    32'd0);
      chk("restart_temp",  32'(temp_val), 32'd0);
      chk("restart_time",  32'(time_val), 32'd0);

      sw = 4'd4; @(negedge clk);
      tap(0, 1, 0);
      sw = 4'd6; tap(1, 0, 0);
      tap(1, 0, 0);
      chk("sim_pre_cursor", 32'(cursor), 32'd2);
      tap(1, 0, 1);
      chk("sim_clear_time",   32'(time_val), 32'd0);
      chk("sim_clear_cursor", 32'(cursor),   32'd0);
      chk("sim_clear_field",  32'(field),    32'd1);
      temp_snap = temp_val;
      tap(0, 1, 0);
      chk("back_field", 32'(field),    32'd0);
      chk("back_temp",  32'(temp_val), 32'h004);
      chk("back_snap",  32'(temp_val), 32'(temp_snap));

      cur_snap = cursor;
      @(negedge clk);
      btn_next_n = 1'b0;
      @(negedge clk); chk("hold_lat0", 32'(cursor), 32'(cur_snap));
      @(negedge clk); chk("hold_lat1", 32'(cursor), 32'(cur_snap));
      @(negedge clk); chk("hold_lat2", 32'(cursor), 32'(cur_snap) + 32'd1);
      repeat (47) @(negedge clk);
      chk("hold_once", 32'(cursor), 32'(cur_snap) + 32'd1);
      btn_next_n = 1'b1;
      repeat (3) @(negedge clk);
      tap(1, 0, 0);
      chk("hold_second", 32'(cursor), 32'(cur_snap) + 32'd2);

      tap(0, 1, 0);
      sw = 4'd7; tap(1, 0, 0);
      tap(1, 0, 0);
      chk("mid_cursor", 32'(cursor), 32'd2);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_field",  32'(field),    32'd0);
      chk("mid_rst_done",   32'(done),     32'd0);
      chk("mid_rst_temp",   32'(temp_val), 32'd0);
      chk("mid_rst_time",   32'(time_val), 32'd0);
      chk("mid_rst_cursor", 32'(cursor),   32'd0);
      rst = 1'b0;

      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         sw          = DW'($urandom_range(0, 15));
         btn_next_n  = ($urandom_range(0, 2)  != 0);
         btn_field_n = ($urandom_range(0, 11) != 0);
         btn_clear_n = ($urandom_range(0, 24) != 0);
         rst         = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0; btn_next_n = 1'b1; btn_field_n = 1'b1; btn_clear_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      summary();
      $finish;
   end

endmodule
